alu_rr_arbiter: RTL

- Round-robin arbiter and sequencer that shares one combinational 32-bit ALU among NUM_REQ requesters.
- Accepts one operation at a time through a valid/ready handshake and drives the ALU operand and control inputs from registers.
- Captures the ALU result and zero flag, then returns them on a shared response port tagged with the requester index.
- Sits between issuing units (e.g. multi-cycle datapath stages) and the single ALU instance.

---
 rtl/alu_rr_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin arbiter that shares one combinational ALU
// among NUM_REQ requesters. One operation is in flight at a time:
// IDLE (grant/accept) -> EXEC (drive ALU, capture result) -> RESP (return).
// Optional feature macro: ALU_OPCHECK_EN adds resp_err and forces a
// zero result with zero flag set for the illegal opcodes 100/110/111.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [3*NUM_REQ-1:0]   req_op,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [2:0]             alu_ctrl,
  input  logic [31:0]            alu_result,
  input  logic                   alu_zero,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [31:0]            resp_result,
  output logic                   resp_zero,
`ifdef ALU_OPCHECK_EN
  output logic                   resp_err,
`endif
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // NUM_REQ expressed in the distance width (one bit wider than an index)
  localparam logic [ID_W:0] NUM_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;
  logic [ID_W-1:0]   id_reg, id_next;
  logic [31:0]       a_reg, a_next;
  logic [31:0]       b_reg, b_next;
  logic [2:0]        op_reg, op_next;
  logic [31:0]       result_reg, result_next;
  logic              zero_reg, zero_next;
`ifdef ALU_OPCHECK_EN
  logic              err_reg, err_next;
`endif

  logic              gnt_any;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W:0]     best_dist;
  logic [31:0]       sel_a;
  logic [31:0]       sel_b;
  logic [2:0]        sel_op;

  // Distance of requester idx from the round-robin pointer, with wrap-around
  function automatic logic [ID_W:0] rr_dist(input logic [ID_W:0] idx,
                                             input logic [ID_W:0] base);
    if (idx >= base) begin
      return idx - base;
    end
    return idx + NUM_W - base;
  endfunction

  // Pick the valid requester closest to ptr (searching upward, wrapping)
  always_comb begin
    gnt_any   = 1'b0;
    gnt_id    = '0;
    best_dist = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] &&
          (!gnt_any || rr_dist((ID_W+1)'(i), {1'b0, ptr_reg}) < best_dist)) begin
        gnt_any   = 1'b1;
        best_dist = rr_dist((ID_W+1)'(i), {1'b0, ptr_reg});
        gnt_id    = ID_W'(i);
      end
    end
  end

  // One-hot ready (only in IDLE) and operand mux for the winning requester
  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_op    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        sel_a        = req_a[32*i +: 32];
        sel_b        = req_b[32*i +: 32];
        sel_op       = req_op[3*i +: 3];
        req_ready[i] = gnt_any && (state_reg == IDLE);
      end
    end
  end

  // Next-state logic: accept in IDLE, capture ALU output in EXEC, hand off in RESP
  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    id_next     = id_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    op_next     = op_reg;
    result_next = result_reg;
    zero_next   = zero_reg;
`ifdef ALU_OPCHECK_EN
    err_next    = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (gnt_any) begin
          a_next     = sel_a;
          b_next     = sel_b;
          op_next    = sel_op;
          id_next    = gnt_id;
          ptr_next   = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        result_next = alu_result;
        zero_next   = alu_zero;
`ifdef ALU_OPCHECK_EN
        // Opcodes 100/110/111 have no defined ALU meaning: flag and neutralise
        err_next = (op_reg == 3'b100) || (op_reg == 3'b110) || (op_reg == 3'b111);
        if (err_next) begin
          result_next = '0;
          zero_next   = 1'b1;
        end
`endif
        state_next = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      id_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
`ifdef ALU_OPCHECK_EN
      err_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      id_reg     <= id_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      op_reg     <= op_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
`ifdef ALU_OPCHECK_EN
      err_reg    <= err_next;
`endif
    end
  end

  assign alu_a       = a_reg;
  assign alu_b       = b_reg;
  assign alu_ctrl    = op_reg;
  assign resp_valid  = (state_reg == RESP);
  assign resp_id     = id_reg;
  assign resp_result = result_reg;
  assign resp_zero   = zero_reg;
  assign busy        = (state_reg != IDLE);
`ifdef ALU_OPCHECK_EN
  assign resp_err    = err_reg && (state_reg == RESP);
`endif

endmodule
